flash_write: RTL and testbench

- SPI-flash write/erase sequencer, the program-side counterpart of the flash read controller.
- Sits between the application and the shared byte-level SPI engine, on the same req/din/done/dout/finish interface.
- Performs Write Enable, then Page Program or Sector Erase, then polls Read Status Register until WIP clears.
- Reports completion with a single-cycle pulse.

---
 rtl/flash_write.sv | 200 ++++++++++++++++++++
 tb/tb_flash_write.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/flash_write.sv
// flash_write: SPI-flash WREN + page-program/sector-erase sequencer with RDSR polling; FLASH_WR_TIMEOUT_EN bounds polling at MAX_POLL
module flash_write #(
  parameter int         DATA_BYTES = 4,
  parameter int         GAP_CYC    = 10,
  parameter logic [7:0] CMD_WREN   = 8'h06,
  parameter logic [7:0] CMD_PP     = 8'h02,
  parameter logic [7:0] CMD_SE     = 8'hD8,
  parameter logic [7:0] CMD_RDSR   = 8'h05,
  parameter int         MAX_POLL   = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        er_en,
  input  logic [23:0] addr,
  input  logic [7:0]  wrdata,
  output logic        wrdata_req,
  output logic        busy,
  output logic        wrdone,
  output logic [7:0]  status,
  input  logic        done,
  input  logic [7:0]  dout,
  output logic        req,
  output logic [7:0]  din,
  output logic        finish,
  output logic        err
);
  typedef enum logic [3:0] {IDLE, WREN, GAP, CMD, ADDR, DATA, RDSR_CMD, RDSR_DATA, DONE} state_t;
  localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  state_t state, state_n, ret, ret_n;
  logic op, op_n, out, out_n, dsel, dsel_n, d;
  logic req_n, finish_n, wrdata_req_n, busy_n, wrdone_n;
  logic [23:0] a, a_n;
  logic [8:0] cnt, cnt_n;
  logic [GW-1:0] gcnt, gcnt_n;
  logic [7:0] din_q, din_n, status_n;
`ifdef FLASH_WR_TIMEOUT_EN
  logic [15:0] pcnt, pcnt_n;
  logic err_q, err_n;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif
  assign d = done & out;
  assign din = dsel ? wrdata : din_q;
  always_comb begin
    state_n = state;
    ret_n = ret;
    op_n = op;
    a_n = a;
    cnt_n = cnt;
    gcnt_n = gcnt;
    out_n = out;
    dsel_n = 1'b0;
    req_n = 1'b0;
    din_n = din;
    finish_n = 1'b0;
    wrdata_req_n = 1'b0;
    busy_n = busy;
    wrdone_n = 1'b0;
    status_n = status;
`ifdef FLASH_WR_TIMEOUT_EN
    pcnt_n = pcnt;
    err_n = err_q;
`endif
    case (state)
      IDLE: if (wr_en | er_en) begin
        state_n = WREN;
        op_n = wr_en;
        a_n = addr;
        busy_n = 1'b1;
        req_n = 1'b1;
        din_n = CMD_WREN;
        out_n = 1'b1;
`ifdef FLASH_WR_TIMEOUT_EN
        pcnt_n = 16'd0;
        err_n = 1'b0;
`endif
      end
      WREN: if (d) begin
        state_n = GAP;
        ret_n = CMD;
        finish_n = 1'b1;
        out_n = 1'b0;
      end
      GAP: if (gcnt == GW'(GAP_CYC - 1)) begin
        state_n = ret;
        gcnt_n = '0;
        req_n = 1'b1;
        out_n = 1'b1;
        din_n = (ret == CMD) ? (op ? CMD_PP : CMD_SE) : CMD_RDSR;
      end else gcnt_n = gcnt + 1'b1;
      CMD: if (d) begin
        state_n = ADDR;
        cnt_n = 9'd1;
        req_n = 1'b1;
        din_n = a[23:16];
      end
      ADDR: if (d) begin
        if (cnt == 9'd3) begin
          out_n = 1'b0;
          cnt_n = 9'd0;
          state_n = op ? DATA : GAP;
          ret_n = RDSR_CMD;
          wrdata_req_n = op;
          finish_n = !op;
        end else begin
          cnt_n = cnt + 9'd1;
          req_n = 1'b1;
          din_n = (cnt == 9'd1) ? a[15:8] : a[7:0];
        end
      end
      DATA: if (wrdata_req) begin
        req_n = 1'b1;
        dsel_n = 1'b1;
        out_n = 1'b1;
        cnt_n = cnt + 9'd1;
      end else if (d) begin
        out_n = 1'b0;
        if (cnt == 9'(DATA_BYTES)) begin
          state_n = GAP;
          ret_n = RDSR_CMD;
          finish_n = 1'b1;
        end else wrdata_req_n = 1'b1;
      end
      RDSR_CMD: if (d) begin
        state_n = RDSR_DATA;
        req_n = 1'b1;
        din_n = 8'h00;
      end
      RDSR_DATA: if (d) begin
        out_n = 1'b0;
        status_n = dout;
        finish_n = 1'b1;
        if (!dout[0]) begin
          state_n = DONE;
          wrdone_n = 1'b1;
          busy_n = 1'b0;
        end else begin
          state_n = GAP;
          ret_n = RDSR_CMD;
`ifdef FLASH_WR_TIMEOUT_EN
          pcnt_n = pcnt + 16'd1;
          if (pcnt_n == 16'(MAX_POLL)) begin
            state_n = IDLE;
            wrdone_n = 1'b1;
            busy_n = 1'b0;
            err_n = 1'b1;
          end
`endif
        end
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ret <= IDLE;
      op <= 1'b0;
      a <= '0;
      cnt <= '0;
      gcnt <= '0;
      out <= 1'b0;
      dsel <= 1'b0;
      req <= 1'b0;
      din_q <= 8'h00;
      finish <= 1'b0;
      wrdata_req <= 1'b0;
      busy <= 1'b0;
      wrdone <= 1'b0;
      status <= 8'h00;
`ifdef FLASH_WR_TIMEOUT_EN
      pcnt <= '0;
      err_q <= 1'b0;
`endif
    end else begin
      state <= state_n;
      ret <= ret_n;
      op <= op_n;
      a <= a_n;
      cnt <= cnt_n;
      gcnt <= gcnt_n;
      out <= out_n;
      dsel <= dsel_n;
      req <= req_n;
      din_q <= din_n;
      finish <= finish_n;
      wrdata_req <= wrdata_req_n;
      busy <= busy_n;
      wrdone <= wrdone_n;
      status <= status_n;
`ifdef FLASH_WR_TIMEOUT_EN
      pcnt <= pcnt_n;
      err_q <= err_n;
`endif
    end
  end
endmodule

// File: tb/tb_flash_write.sv
// tb_flash_write: scoreboard bench for flash_write with a behavioural SPI byte engine
module tb_flash_write;
  localparam int GC = 10;
  localparam int MP = 4;
  logic clk = 1'b0, rst = 1'b1, wr_en = 1'b0, er_en = 1'b0, done = 1'b0;
  logic [23:0] addr = '0;
  logic [7:0] wrdata = 8'h00, dout = 8'h00, status, din;
  logic wrdata_req, busy, wrdone, req, finish, err;
  int checks = 0, failures = 0;
  int cyc = 0, n_fin = 0, n_wdone = 0, n_wreq = 0, last_fin = 0;
  int idx = 0, cd = 0;
  bit pend = 0, rdsr = 0, want_req = 0, exp_err = 0;
  logic [7:0] resp = 8'h00;
  logic [7:0] exp_q[$], st_q[$], wd_q[$];

  flash_write #(.DATA_BYTES(4), .GAP_CYC(GC), .MAX_POLL(MP)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .er_en(er_en), .addr(addr),
    .wrdata(wrdata), .wrdata_req(wrdata_req), .busy(busy), .wrdone(wrdone),
    .status(status), .done(done), .dout(dout), .req(req), .din(din),
    .finish(finish), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    done = 1'b0;
    if (rst) begin
      pend = 0;
      idx = 0;
      want_req = 0;
    end else begin
      if (want_req) begin
        check("wreq_then_req", req, 1);
        want_req = 0;
      end
      if (req | finish) check("req_with_finish", req & finish, 0);
      if (finish) begin
        n_fin++;
        idx = 0;
        last_fin = cyc;
      end
      if (wrdata_req) begin
        n_wreq++;
        want_req = 1;
        wrdata = (wd_q.size() > 0) ? wd_q.pop_front() : 8'h00;
      end
      if (wrdone) begin
        n_wdone++;
        check("busy_at_wrdone", busy, 0);
        check("err_at_wrdone", err, exp_err);
      end
      if (req) begin
        if (exp_q.size() > 0) check("spi_byte", din, exp_q.pop_front());
        else check("extra_byte", exp_q.size(), 1);
        if (idx == 0) begin
          rdsr = (din == 8'h05);
          if (rdsr) check("cs_gap", (cyc - last_fin) >= GC, 1);
        end
        resp = (idx == 1 && rdsr) ? ((st_q.size() > 0) ? st_q.pop_front() : 8'h00) : 8'hFF;
        idx++;
        pend = 1;
        cd = 3;
      end else if (pend) begin
        cd--;
        if (cd == 0) begin
          done = 1'b1;
          dout = resp;
          pend = 0;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic start_op(input bit w, input bit e, input logic [23:0] ad);
    wr_en = w;
    er_en = e;
    addr = ad;
    tick(1);
    wr_en = 0;
    er_en = 0;
  endtask

  task automatic wait_wrdone(input int w0);
    int t = 0;
    while (n_wdone == w0 && t < 3000) begin
      tick(1);
      t++;
    end
    check("wrdone_timeout", t < 3000, 1);
  endtask

  task automatic push_bytes(input logic [7:0] b[]);
    foreach (b[i]) exp_q.push_back(b[i]);
  endtask

  initial begin
    int f0, w0, r0;
    tick(3);
    check("rst_req", req, 0);
    check("rst_din", din, 8'h00);
    check("rst_finish", finish, 0);
    check("rst_wdreq", wrdata_req, 0);
    check("rst_busy", busy, 0);
    check("rst_wrdone", wrdone, 0);
    check("rst_status", status, 8'h00);
    check("rst_err", err, 0);
    rst = 0;
    tick(2);
    // erase, immediate ready
    push_bytes('{8'h06, 8'hD8, 8'h01, 8'h23, 8'h45, 8'h05, 8'h00});
    st_q = '{8'h00};
    f0 = n_fin; w0 = n_wdone;
    start_op(0, 1, 24'h012345);
    check("busy_start", busy, 1);
    wait_wrdone(w0);
    tick(5);
    check("er_finishes", n_fin - f0, 3);
    check("er_wrdone", n_wdone - w0, 1);
    check("er_status", status, 8'h00);
    check("er_left", exp_q.size(), 0);
    // page program
    push_bytes('{8'h06, 8'h02, 8'h00, 8'h01, 8'h00, 8'hAA, 8'h55, 8'h01, 8'hFE, 8'h05, 8'h00});
    wd_q = '{8'hAA, 8'h55, 8'h01, 8'hFE};
    st_q = '{8'h00};
    f0 = n_fin; w0 = n_wdone; r0 = n_wreq;
    start_op(1, 0, 24'h000100);
    wait_wrdone(w0);
    tick(5);
    check("pp_wdreqs", n_wreq - r0, 4);
    check("pp_finishes", n_fin - f0, 3);
    check("pp_wrdone", n_wdone - w0, 1);
    check("pp_left", exp_q.size(), 0);
    // erase with WIP for two polls
    push_bytes('{8'h06, 8'hD8, 8'hAB, 8'hCD, 8'hEF, 8'h05, 8'h00, 8'h05, 8'h00, 8'h05, 8'h00});
    st_q = '{8'h03, 8'h03, 8'h00};
    f0 = n_fin; w0 = n_wdone;
    start_op(0, 1, 24'hABCDEF);
    wait_wrdone(w0);
    tick(5);
    check("poll_finishes", n_fin - f0, 5);
    check("poll_wrdone", n_wdone - w0, 1);
    check("poll_status", status, 8'h00);
    check("poll_left", exp_q.size(), 0);
    // simultaneous start, then a start while busy
    push_bytes('{8'h06, 8'h02, 8'h00, 8'h00, 8'h10, 8'h11, 8'h22, 8'h33, 8'h44, 8'h05, 8'h00});
    wd_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    st_q = '{8'h00};
    w0 = n_wdone;
    start_op(1, 1, 24'h000010);
    tick(20);
    check("busy_mid", busy, 1);
    start_op(0, 1, 24'h777777);
    wait_wrdone(w0);
    tick(200);
    check("both_wrdone", n_wdone - w0, 1);
    check("both_left", exp_q.size(), 0);
    check("both_idle", busy, 0);
    // reset during data byte 2
    push_bytes('{8'h06, 8'h02, 8'h00, 8'h02, 8'h00, 8'h01, 8'h02});
    wd_q = '{8'h01, 8'h02, 8'h03, 8'h04};
    r0 = n_wreq;
    start_op(1, 0, 24'h000200);
    begin
      int t = 0;
      while (n_wreq - r0 < 2 && t < 1000) begin
        tick(1);
        t++;
      end
      check("reach_byte2", t < 1000, 1);
    end
    tick(2);
    f0 = n_fin;
    rst = 1;
    tick(1);
    check("mid_rst_req", req, 0);
    check("mid_rst_finish", finish, 0);
    check("mid_rst_wdreq", wrdata_req, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_din", din, 8'h00);
    rst = 0;
    tick(5);
    check("mid_rst_nofin", n_fin - f0, 0);
    check("mid_rst_left", exp_q.size(), 0);
    exp_q.delete();
    wd_q.delete();
    push_bytes('{8'h06, 8'hD8, 8'h00, 8'h00, 8'h00, 8'h05, 8'h00});
    st_q = '{8'h00};
    w0 = n_wdone;
    start_op(0, 1, 24'h000000);
    wait_wrdone(w0);
    tick(5);
    check("restart_left", exp_q.size(), 0);
    // status stuck at WIP
    push_bytes('{8'h06, 8'hD8, 8'h00, 8'h40, 8'h00});
`ifdef FLASH_WR_TIMEOUT_EN
    for (int i = 0; i < MP; i++) begin
      push_bytes('{8'h05, 8'h00});
      st_q.push_back(8'h01);
    end
    exp_err = 1;
`else
    for (int i = 0; i < MP + 2; i++) begin
      push_bytes('{8'h05, 8'h00});
      st_q.push_back(8'h01);
    end
    push_bytes('{8'h05, 8'h00});
    st_q.push_back(8'h00);
`endif
    w0 = n_wdone;
    start_op(0, 1, 24'h004000);
    wait_wrdone(w0);
    tick(50);
    check("to_wrdone", n_wdone - w0, 1);
    check("to_left", exp_q.size(), 0);
    check("to_busy", busy, 0);
`ifdef FLASH_WR_TIMEOUT_EN
    check("to_err_held", err, 1);
    check("to_status", status, 8'h01);
`else
    check("to_err_zero", err, 0);
    check("to_status", status, 8'h00);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=1 exp=0");
    $fatal(1);
  end
endmodule
